swervolf_gpio: RTL
==================

# swervolf_gpio

Parametrised Wishbone GPIO controller for SweRVolf. Replaces the single fixed `o_gpio` output bit with WIDTH bidirectional channels, each with direction control, two-stage input synchronisation, shared-prescaler debounce and per-channel edge interrupts. Sits on the core's 32-bit Wishbone peripheral bus; board toplevels connect `o_gpio`/`o_gpio_oe`/`i_gpio` to LED, switch and PMOD pins, and `o_irq` to a core external interrupt line.

## Interface

Parameters:
- WIDTH, 8: number of channels, legal range 1..32.
- DEB_W, 16: debounce limit/counter width, legal range 1..32.
- DEB_RST, 0: reset value of DEB_LIMIT.

Ports:
- clk  in  1  single clock for the whole block.
- rstn  in  1  asynchronous reset, active-low; clears all state.
- i_wb_adr  in  4  word address, `adr[5:2]`.
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte enables.
- i_wb_we  in  1  write strobe.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe.
- o_wb_rdt  out  32  read data, registered.
- o_wb_ack  out  1  single-cycle acknowledge.
- i_gpio  in  WIDTH  pad inputs, asynchronous.
- o_gpio  out  WIDTH  pad output values (DATA_OUT).
- o_gpio_oe  out  WIDTH  pad output enables (DIR).
- o_irq  out  1  level interrupt, `|(IRQ_STATUS & IRQ_EN)`.

## Operation

Register map (byte offset). Bits ≥ WIDTH read 0 and ignore writes. Writes honour `i_wb_sel` per byte.
- 0x00 DATA_OUT rw.
- 0x04 DIR rw; 1 = output.
- 0x08 DATA_IN ro; debounced inputs, all channels regardless of DIR.
- 0x0C IRQ_EN rw.
- 0x10 RISE_EN rw.
- 0x14 FALL_EN rw.
- 0x18 IRQ_STATUS rw1c.
- 0x1C DEB_LIMIT rw, DEB_W bits, upper bits read 0.
- 0x20 SET wo; DATA_OUT |= masked data. Reads 0.
- 0x24 CLR wo; DATA_OUT &= ~masked data. Reads 0.
- 0x28–0x3C unmapped; reads 0, writes ignored, still acked.

Input path per channel: `sync1 <= i_gpio`, `sync2 <= sync1`.
- Shared prescaler `cnt`, DEB_W bits. Each cycle: if `cnt >= DEB_LIMIT`, assert `tick` and set `cnt <= 0`; otherwise `cnt <= cnt + 1`.
  - A tick occurs every DEB_LIMIT+1 cycles.
  - Lowering DEB_LIMIT below `cnt` produces a tick on the next cycle.
- On tick: `samp <= sync2`. For each bit where `sync2 == samp`, `deb <= sync2`. Other bits hold.
- Edge events are computed from `deb_next` vs `deb`, in the same cycle `deb` updates.
  - Rise (0→1) with RISE_EN set: sets STATUS bit.
  - Fall (1→0) with FALL_EN set: sets STATUS bit.
- Same-cycle STATUS write-1-clear and a new event on the same bit: set wins.
- IRQ_EN only masks `o_irq`; STATUS records events regardless of IRQ_EN.
- `o_irq` is combinational from registers; no extra latency beyond the register update.

## Timing

- Bus transaction: `cyc & stb & !ack` at edge E → `o_wb_ack = 1` for exactly one cycle after E, with `o_wb_rdt` valid in that cycle.
  - The write takes effect at edge E.
  - Ack deasserts for at least one cycle between transfers, so the minimum period is 2 cycles per access.
- Outputs: `o_gpio` and `o_gpio_oe` change the cycle after the write edge.
- Input latency with DEB_LIMIT = 0, pin changing before edge E0:
  - `sync2` new at E1, `samp` new at E2.
  - DATA_IN, STATUS and `o_irq` update at E3: 3 cycles.
- Input latency with limit L: stable ≥ 2(L+1)+2 cycles guarantees acceptance. A pulse shorter than L+1 cycles can never be accepted.
- Reset values, all zero: `o_wb_ack`, `o_wb_rdt`, `o_gpio`, `o_gpio_oe`, `o_irq`, and all sync/samp/deb/cnt/STATUS state. DEB_LIMIT resets to DEB_RST.
- Asserting `rstn` mid-transfer drops the ack and discards any pending write.
- After reset, RISE_EN/FALL_EN = 0, so no spurious events are recorded.

## Test plan

- Reset, then read all registers → every read is 0 except DEB_LIMIT = DEB_RST; `o_irq` = 0. Unmapped 0x30 read → acked, data 0.
- Write DATA_OUT = 0xA5 and DIR = 0x0F, then SET 0x02 and CLR 0x80 → `o_gpio` = 0x27, `o_gpio_oe` = 0x0F, each change one cycle after its write. A write with `sel` = 4'b0010 of 0xFFFF_FFFF to DATA_OUT → only bits 15:8 change (WIDTH = 16 build).
- DEB_LIMIT = 0, RISE_EN[3] = 1, IRQ_EN[3] = 1; raise `i_gpio[3]` → DATA_IN[3] and `o_irq` high exactly 3 cycles later. Write 0x08 to STATUS → `o_irq` low the next cycle.
- DEB_LIMIT = 9: 5-cycle glitch on `i_gpio[0]` → DATA_IN unchanged, STATUS = 0. A 30-cycle level → accepted within 22 cycles; with FALL_EN[0] = 1, release → STATUS[0] = 1.
- Write-1-clear STATUS[2] in the same cycle a new rise on channel 2 is accepted → STATUS[2] stays 1, `o_irq` stays high.
- Assert `rstn` low mid-debounce with the pin held high, then release → all outputs 0. DATA_IN reads 1 only after a fresh debounce. No STATUS bits set.

Source files
------------

// File: rtl/swervolf_gpio.sv
// Wishbone GPIO controller: WIDTH bidirectional channels with two-flop input
// sync, shared-prescaler debounce and per-channel rise/fall interrupts.

module swervolf_gpio_chan (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  input  logic pin,
  input  logic rise_en,
  input  logic fall_en,
  input  logic sta_clr,
  output logic deb,
  output logic sta
);
  logic sync1, sync2, samp;
  logic deb_next, rise, fall;

  // a level is accepted only when it was seen on two consecutive ticks
  assign deb_next = (tick && (sync2 == samp)) ? sync2 : deb;
  assign rise     = deb_next & ~deb;
  assign fall     = ~deb_next & deb;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      samp  <= 1'b0;
      deb   <= 1'b0;
      sta   <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (tick) samp <= sync2;
      deb   <= deb_next;
      // a new event beats a same-cycle write-1-clear
      sta   <= (sta & ~sta_clr) | (rise & rise_en) | (fall & fall_en);
    end
  end
endmodule

module swervolf_gpio #(
  parameter int WIDTH   = 8,
  parameter int DEB_W   = 16,
  parameter int DEB_RST = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);
  localparam logic [3:0] A_DOUT = 4'h0;
  localparam logic [3:0] A_DIR  = 4'h1;
  localparam logic [3:0] A_DIN  = 4'h2;
  localparam logic [3:0] A_IEN  = 4'h3;
  localparam logic [3:0] A_REN  = 4'h4;
  localparam logic [3:0] A_FEN  = 4'h5;
  localparam logic [3:0] A_STA  = 4'h6;
  localparam logic [3:0] A_DEB  = 4'h7;
  localparam logic [3:0] A_SET  = 4'h8;
  localparam logic [3:0] A_CLR  = 4'h9;

  typedef struct packed {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [31:0] mask;
  } wb_req_t;

  wb_req_t          req;
  logic             req_vld, wr;
  logic [WIDTH-1:0] wmask, wdat;
  logic [WIDTH-1:0] data_out, dir, irq_en, rise_en, fall_en;
  logic [WIDTH-1:0] din, sta, sta_clr;
  logic [DEB_W-1:0] deb_limit, cnt, dl_mask, dl_dat;
  logic             tick;
  logic [31:0]      rd;
  logic             unused_bits;

  assign req.we   = i_wb_we;
  assign req.adr  = i_wb_adr;
  assign req.dat  = i_wb_dat;
  assign req.mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};

  // ack is held off for a cycle after each access so a held strobe is not re-accepted
  assign req_vld = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr      = req_vld & req.we;

  assign wmask   = req.mask[WIDTH-1:0];
  assign wdat    = req.dat[WIDTH-1:0];
  assign dl_mask = req.mask[DEB_W-1:0];
  assign dl_dat  = req.dat[DEB_W-1:0];
  assign sta_clr = (wr && req.adr == A_STA) ? (wdat & wmask) : '0;

  assign unused_bits = ^{req.dat, req.mask};

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] cur,
                                             input logic [WIDTH-1:0] d,
                                             input logic [WIDTH-1:0] m);
    return (cur & ~m) | (d & m);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out  <= '0;
      dir       <= '0;
      irq_en    <= '0;
      rise_en   <= '0;
      fall_en   <= '0;
      deb_limit <= DEB_W'(DEB_RST);
    end else if (wr) begin
      case (req.adr)
        A_DOUT:  data_out  <= merge(data_out, wdat, wmask);
        A_DIR:   dir       <= merge(dir, wdat, wmask);
        A_IEN:   irq_en    <= merge(irq_en, wdat, wmask);
        A_REN:   rise_en   <= merge(rise_en, wdat, wmask);
        A_FEN:   fall_en   <= merge(fall_en, wdat, wmask);
        A_DEB:   deb_limit <= (deb_limit & ~dl_mask) | (dl_dat & dl_mask);
        A_SET:   data_out  <= data_out | (wdat & wmask);
        A_CLR:   data_out  <= data_out & ~(wdat & wmask);
        default: ;
      endcase
    end
  end

  // >= rather than == so lowering the limit below cnt still ticks promptly
  assign tick = (cnt >= deb_limit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= '0;
    else       cnt <= tick ? '0 : cnt + DEB_W'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    swervolf_gpio_chan u_chan (
      .clk     (clk),
      .rstn    (rstn),
      .tick    (tick),
      .pin     (i_gpio[i]),
      .rise_en (rise_en[i]),
      .fall_en (fall_en[i]),
      .sta_clr (sta_clr[i]),
      .deb     (din[i]),
      .sta     (sta[i])
    );
  end

  always_comb begin
    rd = '0;
    case (req.adr)
      A_DOUT:  rd[WIDTH-1:0] = data_out;
      A_DIR:   rd[WIDTH-1:0] = dir;
      A_DIN:   rd[WIDTH-1:0] = din;
      A_IEN:   rd[WIDTH-1:0] = irq_en;
      A_REN:   rd[WIDTH-1:0] = rise_en;
      A_FEN:   rd[WIDTH-1:0] = fall_en;
      A_STA:   rd[WIDTH-1:0] = sta;
      A_DEB:   rd[DEB_W-1:0] = deb_limit;
      default: rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      o_wb_ack <= req_vld;
      o_wb_rdt <= req_vld ? rd : '0;
    end
  end

  assign o_gpio    = data_out;
  assign o_gpio_oe = dir;
  assign o_irq     = |(sta & irq_en);
endmodule
